pcm_tx_serializer: RTL and testbench

Downstream stage of the linear-to-PCM encoder: accepts 8-bit PCM codes over a valid/ready handshake, buffers them in a small FIFO and transmits them MSB-first as a continuous framed serial stream. Each frame is one PCM byte, marked by a frame-sync strobe on its first bit. Once running, the line never goes quiet. On FIFO underflow the block sends the PCM idle code and flags the underrun. It sits between the encoder output and the serial line driver.

---
 rtl/pcm_pkg.sv | 12 +
 rtl/pcm_fifo.sv | 59 +++++
 rtl/pcm_tx_serializer.sv | 135 +++++++++++++
 tb/tb_pcm_tx_serializer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pcm_pkg.sv
// Shared PCM definitions for the encoder-side serializer and the decoder stage.
package pcm_pkg;

    localparam int PCM_W = 8;
    localparam logic [PCM_W-1:0] PCM_IDLE_CODE = 8'hD5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

endpackage

// File: rtl/pcm_fifo.sv
// Synchronous show-ahead FIFO: rd_data always presents the oldest entry, so it is
// valid in the same cycle that rd_en pops it.
module pcm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_fire;
    logic             rd_fire;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (wr_fire && !rd_fire) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (rd_fire && !wr_fire) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/pcm_tx_serializer.sv
// Buffers PCM bytes and sends them MSB-first as gapless 8-bit frames, with a sync
// strobe on bit 7 and the idle code substituted whenever the FIFO runs dry.
module pcm_tx_serializer
    import pcm_pkg::*;
#(
    parameter int               FIFO_DEPTH = 4,
    parameter int               BIT_DIV    = 4,
    parameter logic [PCM_W-1:0] IDLE_CODE  = PCM_IDLE_CODE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PCM_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_sync,
    output logic             running,
    output logic             underrun,
    output logic [7:0]       underrun_cnt
);

    localparam int DW = $clog2(BIT_DIV);

    tx_state_t        state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [PCM_W-1:0] shreg_q, shreg_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             sync_q, sync_d;
    logic             running_q, running_d;
    logic             underrun_q, underrun_d;
    logic [7:0]       ucnt_q, ucnt_d;

    logic             tick;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PCM_W-1:0] fifo_rd_data;

    pcm_fifo #(
        .WIDTH (PCM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tick  = (div_q == DW'(BIT_DIV - 1));
    assign div_d = tick ? '0 : div_q + DW'(1);

    assign in_ready     = !fifo_full;
    assign ser_out      = shreg_q[PCM_W-1];
    assign ser_sync     = sync_q;
    assign running      = running_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            sync_q     <= 1'b0;
            running_q  <= 1'b0;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            sync_q     <= sync_d;
            running_q  <= running_d;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        sync_d     = sync_q;
        running_d  = running_q;
        underrun_d = 1'b0;
        ucnt_d     = ucnt_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick && !fifo_empty) begin
                    pop       = 1'b1;
                    shreg_d   = fifo_rd_data;
                    bit_idx_d = 3'd7;
                    sync_d    = 1'b1;
                    running_d = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    if (bit_idx_q != 3'd0) begin
                        shreg_d   = {shreg_q[PCM_W-2:0], 1'b0};
                        bit_idx_d = bit_idx_q - 3'd1;
                        sync_d    = 1'b0;
                    end else begin
                        // A push landing on this same edge is only visible next frame.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shreg_d = fifo_rd_data;
                        end else begin
                            shreg_d    = IDLE_CODE;
                            underrun_d = 1'b1;
                            if (ucnt_q != 8'hFF) begin
                                ucnt_d = ucnt_q + 8'd1;
                            end
                        end
                        bit_idx_d = 3'd7;
                        sync_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pcm_tx_serializer.sv
// Cycle-accurate frame-level reference model of the PCM serializer, driven with
// directed and randomized traffic.
module tb_pcm_tx_serializer;

  localparam int BIT_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 8 * BIT_DIV;
  localparam logic [7:0] IDLE_BYTE = 8'hD5;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       ser_out;
  logic       ser_sync;
  logic       running;
  logic       underrun;
  logic [7:0] underrun_cnt;

  always #5 clk = ~clk;

  pcm_tx_serializer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BIT_DIV    (BIT_DIV),
    .IDLE_CODE  (IDLE_BYTE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ser_out      (ser_out),
    .ser_sync     (ser_sync),
    .running      (running),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: pending bytes, edge count since reset, current frame
  logic [7:0] exp_q[$];
  int         m_k = 0;
  bit         m_running = 1'b0;
  int         m_start = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_underrun = 1'b0;
  int         m_cnt = 0;
  bit         m_accepted = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs the DUT just sampled.
  task automatic model_edge();
    bit had_data;
    if (rst) begin
      exp_q.delete();
      m_k = 0;
      m_running = 1'b0;
      m_start = 0;
      m_cur = 8'h00;
      m_underrun = 1'b0;
      m_cnt = 0;
      m_accepted = 1'b0;
      return;
    end
    had_data   = (exp_q.size() > 0);
    m_accepted = in_valid && (exp_q.size() < FIFO_DEPTH);
    m_k++;
    m_underrun = 1'b0;
    if (m_k % BIT_DIV == 0) begin
      if (!m_running) begin
        if (had_data) begin
          m_cur = exp_q.pop_front();
          m_start = m_k;
          m_running = 1'b1;
        end
      end else if (m_k - m_start == FRAME) begin
        if (had_data) begin
          m_cur = exp_q.pop_front();
        end else begin
          m_cur = IDLE_BYTE;
          m_underrun = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
        m_start = m_k;
      end
    end
    if (m_accepted) exp_q.push_back(in_data);
  endtask

  task automatic check_outputs();
    int   b;
    logic exp_out;
    logic exp_sync;
    if (m_running) begin
      b = (m_k - m_start) / BIT_DIV;
      exp_out = m_cur[7 - b];
      exp_sync = (b == 0);
    end else begin
      exp_out = 1'b0;
      exp_sync = 1'b0;
    end
    check_eq("ser_out", ser_out, exp_out);
    check_eq("ser_sync", ser_sync, exp_sync);
    check_eq("running", running, m_running);
    check_eq("underrun", underrun, m_underrun);
    check_eq("underrun_cnt", underrun_cnt, m_cnt);
    check_eq("in_ready", in_ready, exp_q.size() < FIFO_DEPTH);
  endtask

  // driver tasks
  task automatic step(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    rst = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    int guard;
    guard = 0;
    do begin
      step(1'b1, d);
      guard++;
    end while (!m_accepted && guard < 500);
    check_eq("push_accepted", m_accepted, 1'b1);
  endtask

  initial begin
    int guard;

    // 1: single byte A5 right after reset
    do_reset();
    push_byte(8'hA5);
    idle_cycles(2 * FRAME + 8);

    // 2: two back-to-back bytes
    do_reset();
    push_byte(8'h3C);
    push_byte(8'hC3);
    idle_cycles(3 * FRAME);

    // 3: single zero byte followed by idle frames
    do_reset();
    push_byte(8'h00);
    idle_cycles(6 * FRAME);

    // 4: six bytes with valid held high while busy
    do_reset();
    for (int i = 0; i < 6; i++) push_byte(8'h10 + 8'(i * 17));
    idle_cycles(8 * FRAME);

    // 5: reset at bit 3 of a frame with the FIFO still holding data
    do_reset();
    push_byte(8'hF0);
    push_byte(8'h11);
    push_byte(8'h22);
    guard = 0;
    while (!(m_running && (m_k - m_start) == 3 * BIT_DIV) && guard < 200) begin
      step(1'b0, 8'h00);
      guard++;
    end
    check_eq("reach_bit3", guard < 200, 1'b1);
    rst = 1'b1;
    step(1'b0, 8'h00);
    rst = 1'b0;
    push_byte(8'h81);
    idle_cycles(2 * FRAME);

    // 6: long underflow run to saturate the counter
    do_reset();
    push_byte(8'h5A);
    idle_cycles(300 * FRAME + 8);
    check_eq("cnt_saturated", underrun_cnt, 8'd255);

    // random traffic: a heavy phase that fills the FIFO, then a sparse phase
    do_reset();
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 3) == 0, 8'($urandom));
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 40) == 0, 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
